// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks a run of ROM addresses and streams each registered word out on valid/ready.
// Optional build macro ROM_STREAM_READER_CHKSUM_EN adds a running XOR checksum output `chksum`.
module rom_stream_reader #(
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 9,
    parameter int START_ADDR = 0,
    parameter int WORD_COUNT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
`ifdef ROM_STREAM_READER_CHKSUM_EN
    output logic              done,
    output logic [DATA_W-1:0] chksum
`else
    output logic              done
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W + 1)'(WORD_COUNT - 1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_count;
    logic [DATA_W-1:0]   r_data;
    logic                r_last;
    logic                w_hs;
    logic                w_accept;

    // out_valid is only ever high in HOLD, so a handshake is HOLD plus ready.
    assign w_hs     = (r_state == S_HOLD) && out_ready;
    assign w_accept = (r_state == S_IDLE) && start;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: default first so no branch leaves w_next unassigned and infers a latch.
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_FETCH;
            S_FETCH: w_next = S_HOLD;
            S_HOLD:  if (w_hs) w_next = r_last ? S_DONE : S_FETCH;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        out_valid = (r_state == S_HOLD);
        done      = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= START_A;
            r_count <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= START_A;
                        r_count <= '0;
                    end
                end
                S_FETCH: begin
                    r_data <= rom_data;
                    r_last <= (r_count == LAST_IDX);
                end
                S_HOLD: begin
                    if (w_hs) begin
                        if (r_last) begin
                            r_last <= 1'b0;
                        end else begin
                            // Address wraps naturally at 2^ADDR_W.
                            r_addr  <= r_addr + 1'b1;
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rom_addr = r_addr;
    assign out_data = r_data;
    assign out_last = r_last;

`ifdef ROM_STREAM_READER_CHKSUM_EN
    logic [DATA_W-1:0] r_chksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chksum <= '0;
        end else if (w_accept) begin
            r_chksum <= '0;
        end else if (w_hs) begin
            r_chksum <= r_chksum ^ r_data;
        end
    end

    assign chksum = r_chksum;
`endif

endmodule
